// File: rtl/cpu_pkg.sv
// Shared CPU types and constants: default word width, stack depth,
// pop-count encodings and the data word typedef.
package cpu_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int DEPTH_DEF = 16;

  localparam logic [1:0] POP_NONE = 2'd0;
  localparam logic [1:0] POP_ONE  = 2'd1;
  localparam logic [1:0] POP_TWO  = 2'd2;

  typedef logic [WIDTH_DEF-1:0] word_t;

endpackage

// File: rtl/stack_mem.sv
// Stack storage: DEPTH x WIDTH, one sync write port, two comb reads.
// Ports: clk, reset (sync clear), we/waddr/wdata, raddr0/1 -> rdata0/1.
module stack_mem
  import cpu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr0,
  input  logic [AW-1:0]    raddr1,
  output logic [WIDTH-1:0] rdata0,
  output logic [WIDTH-1:0] rdata1
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Out-of-range addresses only occur for non power-of-two depths
  // while the caller masks the result anyway; keep them X-free.
  always_comb begin
    rdata0 = '0;
    rdata1 = '0;
    if ({1'b0, raddr0} < DEPTH_W) rdata0 = mem[raddr0];
    if ({1'b0, raddr1} < DEPTH_W) rdata1 = mem[raddr1];
  end

endmodule

// File: rtl/stack_regfile.sv
// Operand stack: presents top two entries, pops 0/1/2 and pushes 1.
// Ports: clk, reset, read_reg1/2, write_reg, wr_data -> rd_top/next, status.
module stack_regfile
  import cpu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             read_reg1,
  input  logic             read_reg2,
  input  logic             write_reg,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_top,
  output logic [WIDTH-1:0] rd_next,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow,
  output logic             op_reject
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_X = (CW+1)'(DEPTH);

  logic [1:0]       npop;
  logic [CW:0]      cnt_x;
  logic [CW:0]      pop_x;
  logic [CW:0]      push_x;
  logic [CW:0]      base_x;
  logic [CW:0]      next_x;
  logic             under;
  logic             over;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    raddr0;
  logic [AW-1:0]    raddr1;
  logic [WIDTH-1:0] rdata0;
  logic [WIDTH-1:0] rdata1;
  logic             we;

  always_comb begin
    npop = POP_NONE;
    unique case (1'b1)
      read_reg2: npop = POP_TWO;
      read_reg1: npop = POP_ONE;
      default:   npop = POP_NONE;
    endcase
  end

  // One extra bit so count - npop + npush never wraps.
  assign cnt_x  = {1'b0, count};
  assign pop_x  = {{(CW-1){1'b0}}, npop};
  assign push_x = {{CW{1'b0}}, write_reg};
  assign base_x = cnt_x - pop_x;
  assign next_x = base_x + push_x;

  assign under     = pop_x > cnt_x;
  assign over      = !under && (next_x > DEPTH_X);
  assign op_reject = under | over;

  // Push lands in the lowest slot freed by this cycle's pops.
  assign waddr  = base_x[AW-1:0];
  assign raddr0 = AW'(count - CW'(1));
  assign raddr1 = AW'(count - CW'(2));
  assign we     = write_reg & ~op_reject;

  stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk    (clk),
    .reset  (reset),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wr_data),
    .raddr0 (raddr0),
    .raddr1 (raddr1),
    .rdata0 (rdata0),
    .rdata1 (rdata1)
  );

  assign rd_top  = (count >= CW'(1)) ? rdata0 : '0;
  assign rd_next = (count >= CW'(2)) ? rdata1 : '0;
  assign empty   = count == '0;
  assign full    = cnt_x == DEPTH_X;

  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (op_reject) begin
      if (under) underflow <= 1'b1;
      else       overflow  <= 1'b1;
    end else begin
      count <= next_x[CW-1:0];
    end
  end

endmodule

// File: tb/tb_stack_regfile.sv
// Directed bench for stack_regfile at DEPTH=4, WIDTH=32.
// Hand-computed expectations, single checking task.
module tb_stack_regfile;

  localparam int W  = 32;
  localparam int D  = 4;
  localparam int CW = $clog2(D+1);

  logic          clk = 1'b0;
  logic          reset;
  logic          read_reg1;
  logic          read_reg2;
  logic          write_reg;
  logic [W-1:0]  wr_data;
  logic [W-1:0]  rd_top;
  logic [W-1:0]  rd_next;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          underflow;
  logic          op_reject;

  int checks = 0;
  int errors = 0;

  stack_regfile #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .read_reg1 (read_reg1),
    .read_reg2 (read_reg2),
    .write_reg (write_reg),
    .wr_data   (wr_data),
    .rd_top    (rd_top),
    .rd_next   (rd_next),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow),
    .op_reject (op_reject)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic r1, input logic r2,
                       input logic w, input logic [31:0] d);
    read_reg1 = r1;
    read_reg2 = r2;
    write_reg = w;
    wr_data   = d;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    read_reg1 = 1'b0;
    read_reg2 = 1'b0;
    write_reg = 1'b0;
    wr_data   = '0;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_top", rd_top, 0);
    chk("rst_next", rd_next, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);

    drive(0, 0, 1, 32'h11);
    chk("p1_no_bypass", rd_top, 0);
    tick();
    chk("p1_top", rd_top, 32'h11);
    drive(0, 0, 1, 32'h22);
    tick();
    chk("p2_top", rd_top, 32'h22);
    chk("p2_next", rd_next, 32'h11);
    drive(0, 0, 1, 32'h33);
    chk("p3_no_bypass", rd_top, 32'h22);
    tick();
    chk("p3_count", count, 3);
    chk("p3_top", rd_top, 32'h33);
    chk("p3_next", rd_next, 32'h22);

    tick();
    chk("noop_count", count, 3);
    chk("noop_top", rd_top, 32'h33);

    drive(0, 1, 1, 32'h55);
    chk("add_rej", op_reject, 0);
    tick();
    chk("add_count", count, 2);
    chk("add_top", rd_top, 32'h55);
    chk("add_next", rd_next, 32'h11);

    drive(0, 0, 1, 32'h66);
    tick();
    drive(0, 0, 1, 32'h77);
    tick();
    chk("fill_count", count, 4);
    chk("fill_full", full, 1);
    drive(0, 0, 1, 32'h99);
    chk("ovf_rej", op_reject, 1);
    tick();
    chk("ovf_flag", overflow, 1);
    chk("ovf_unf", underflow, 0);
    chk("ovf_count", count, 4);
    chk("ovf_top", rd_top, 32'h77);

    drive(1, 0, 1, 32'hAA);
    chk("rep_rej", op_reject, 0);
    tick();
    chk("rep_count", count, 4);
    chk("rep_top", rd_top, 32'hAA);
    chk("rep_next", rd_next, 32'h66);
    chk("rep_ovf", overflow, 1);

    drive(0, 1, 0, 0);
    tick();
    chk("pop2_top", rd_top, 32'h55);
    chk("pop2_next", rd_next, 32'h11);
    drive(1, 0, 0, 0);
    tick();
    chk("pop1_count", count, 1);
    chk("pop1_next", rd_next, 0);

    drive(0, 1, 0, 0);
    chk("unf_rej", op_reject, 1);
    tick();
    chk("unf_flag", underflow, 1);
    chk("unf_count", count, 1);
    chk("unf_top", rd_top, 32'h11);
    drive(1, 0, 0, 0);
    tick();
    chk("last_count", count, 0);
    chk("last_empty", empty, 1);
    chk("last_top", rd_top, 0);

    drive(1, 0, 0, 0);
    chk("empty_pop_rej", op_reject, 1);
    tick();
    chk("empty_pop_count", count, 0);

    drive(0, 0, 1, 32'h01);
    tick();
    drive(0, 0, 1, 32'h02);
    tick();
    drive(0, 1, 1, 32'h03);
    tick();
    chk("p2p_count", count, 1);
    chk("p2p_top", rd_top, 32'h03);
    chk("p2p_next", rd_next, 0);

    drive(0, 0, 1, 32'h04);
    tick();
    drive(0, 0, 1, 32'h05);
    tick();
    chk("pre_rst_count", count, 3);
    reset = 1'b1;
    drive(1, 0, 1, 32'hEE);
    tick();
    reset = 1'b0;
    #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_top", rd_top, 0);
    chk("mid_rst_next", rd_next, 0);
    chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_unf", underflow, 0);
    chk("mid_rst_empty", empty, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
